dmem_arbiter: RTL and testbench

- Two-requester controller sharing the single-port byte-addressed Data_Memory between the pipeline MEM stage (CPU port) and a test loader/checker (DMA port), e.g. preloading and reading back bubble-sort arrays.
- Sits between both requesters and Data_Memory, and drives its Mem_Address/Write_Data/MemWrite/MemRead.
- Round-robin arbitration with a req/gnt handshake, one access per two cycles, and a registered response carrying read data or an error.
- Rejects misaligned and out-of-range doubleword accesses.

---
 rtl/dmem_arbiter_if.sv | 24 ++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields in, grant and
// registered response back. The requester drives master, the arbiter uses slave.
interface dmem_arbiter_if #(
    parameter int DW = 64
);
    logic          req;
    logic          we;
    logic [63:0]   addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of the single-port Data_Memory: one access
// per two cycles, registered response. `DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority.
module dmem_arbiter #(
    parameter int MEM_BYTES = 64,
    parameter int DW        = 64
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave cpu,
    dmem_arbiter_if.slave dma,
    output logic [63:0]   Mem_Address,
    output logic [DW-1:0] Write_Data,
    output logic          MemWrite,
    output logic          MemRead,
    input  logic [DW-1:0] Read_Data,
    output logic          busy
);
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_reg, state_next;
    logic          last_owner_reg;          // 0 = CPU, 1 = DMA
    logic          owner_reg;
    logic          we_reg;
    logic          err_reg;
    logic [63:0]   addr_reg;
    logic [DW-1:0] wdata_reg;

    // Port index 0 is the CPU, index 1 the DMA.
    logic [1:0]    req_vec;
    logic [1:0]    we_vec;
    logic [63:0]   addr_vec  [2];
    logic [DW-1:0] wdata_vec [2];
    logic [1:0]    gnt_vec;
    logic          grant;
    logic          sel;
    logic          err_new;
    logic          access;

    logic          rvalid_reg  [2];
    logic [DW-1:0] rdata_reg   [2];
    logic          rsp_err_reg [2];

    assign req_vec      = {dma.req, cpu.req};
    assign we_vec       = {dma.we, cpu.we};
    assign addr_vec[0]  = cpu.addr;
    assign addr_vec[1]  = dma.addr;
    assign wdata_vec[0] = cpu.wdata;
    assign wdata_vec[1] = dma.wdata;

    always_comb begin
        state_next = state_reg;
        gnt_vec    = 2'b00;
        grant      = 1'b0;
        sel        = 1'b0;
        err_new    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!reset && (req_vec != 2'b00)) begin
                    grant = 1'b1;
                    if (req_vec == 2'b11) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                        sel = 1'b0;
`else
                        sel = ~last_owner_reg;
`endif
                    end else begin
                        sel = req_vec[1];
                    end
                    gnt_vec[sel] = 1'b1;
                    state_next   = ACCESS;
                end
            end
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        err_new = (addr_vec[sel][2:0] != 3'b000) || (addr_vec[sel] > MAX_ADDR);
        if (reset) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
            owner_reg      <= 1'b0;
            we_reg         <= 1'b0;
            err_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_reg      <= sel;
                last_owner_reg <= sel;
                we_reg         <= we_vec[sel];
                err_reg        <= err_new;
                addr_reg       <= addr_vec[sel];
                wdata_reg      <= wdata_vec[sel];
            end
        end
    end

    // Address/data simply hold the last latched request outside ACCESS.
    assign access      = (state_reg == ACCESS);
    assign busy        = access;
    assign Mem_Address = addr_reg;
    assign Write_Data  = wdata_reg;
    assign MemWrite    = access & we_reg & ~err_reg & ~reset;
    assign MemRead     = access & ~we_reg & ~err_reg & ~reset;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge clk) begin
                if (reset || !(access && (owner_reg == 1'(gi)))) begin
                    rvalid_reg[gi]  <= 1'b0;
                    rdata_reg[gi]   <= '0;
                    rsp_err_reg[gi] <= 1'b0;
                end else begin
                    rvalid_reg[gi]  <= 1'b1;
                    rsp_err_reg[gi] <= err_reg;
                    rdata_reg[gi]   <= (!we_reg && !err_reg) ? Read_Data : '0;
                end
            end
        end
    endgenerate

    assign cpu.gnt    = gnt_vec[0];
    assign dma.gnt    = gnt_vec[1];
    assign cpu.rvalid = rvalid_reg[0];
    assign dma.rvalid = rvalid_reg[1];
    assign cpu.rdata  = rdata_reg[0];
    assign dma.rdata  = rdata_reg[1];
    assign cpu.err    = rsp_err_reg[0];
    assign dma.err    = rsp_err_reg[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, every cycle
// checked against a transaction-level model (grant timeline + shadow memory).
module tb_dmem_arbiter;
    localparam int MEM_BYTES = 64;
    localparam int DW        = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   Mem_Address;
    logic [DW-1:0] Write_Data;
    logic          MemWrite, MemRead, busy;
    logic [DW-1:0] Read_Data;
    logic          preload;

    dmem_arbiter_if #(.DW(DW)) cpu_bus ();
    dmem_arbiter_if #(.DW(DW)) dma_bus ();

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .DW(DW)) dut (
        .clk(clk), .reset(reset), .cpu(cpu_bus), .dma(dma_bus),
        .Mem_Address(Mem_Address), .Write_Data(Write_Data),
        .MemWrite(MemWrite), .MemRead(MemRead), .Read_Data(Read_Data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Data_Memory stand-in: byte array, little-endian, combinational read.
    logic [7:0] mem [MEM_BYTES];
    always_comb begin
        Read_Data = '0;
        if (Mem_Address <= 64'(MEM_BYTES - 8))
            for (int i = 0; i < 8; i++) Read_Data[8*i +: 8] = mem[int'(Mem_Address) + i];
    end
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h02;
            mem[8] <= 8'h01;
        end else if (MemWrite && Mem_Address <= 64'(MEM_BYTES - 8)) begin
            for (int i = 0; i < 8; i++) mem[int'(Mem_Address) + i] <= Write_Data[8*i +: 8];
        end
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: a grant in cycle N books the memory for N+1 and the
    // response for N+2; the shadow memory is indexed by doubleword.
    logic [63:0] shadow [MEM_BYTES/8];
    int          cyc = 0;
    bit          m_last = 1'b1;
    bit          acc_v = 1'b0, acc_own, acc_we, acc_err;
    int          acc_cyc;
    logic [63:0] acc_addr, acc_wdata;
    bit          rsp_v = 1'b0, rsp_own, rsp_err;
    int          rsp_cyc;
    logic [63:0] rsp_data;

    bit          s_gnt [2], s_rv [2], s_err [2];
    logic [63:0] s_rdata [2];
    bit          s_busy, s_mw, s_mr;

    task automatic model_check();
        bit          in_acc, rsp_now, own, any;
        bit          req_c, req_d, eg_c, eg_d;
        logic [63:0] a;
        rsp_now = rsp_v && (rsp_cyc == cyc);
        chk("cpu_rvalid", s_rv[0], 64'(rsp_now && !rsp_own));
        chk("dma_rvalid", s_rv[1], 64'(rsp_now && rsp_own));
        chk("cpu_rdata", s_rdata[0], (rsp_now && !rsp_own) ? rsp_data : 64'd0);
        chk("dma_rdata", s_rdata[1], (rsp_now && rsp_own) ? rsp_data : 64'd0);
        chk("cpu_err", s_err[0], 64'(rsp_now && !rsp_own && rsp_err));
        chk("dma_err", s_err[1], 64'(rsp_now && rsp_own && rsp_err));
        if (rsp_now) begin
            $display("rsp cyc=%0d port=%s rdata=%h err=%0d", cyc, rsp_own ? "dma" : "cpu", rsp_data, rsp_err);
            rsp_v = 1'b0;
        end

        in_acc = acc_v && (acc_cyc == cyc);
        chk("busy", s_busy, 64'(in_acc));
        chk("MemWrite", s_mw, 64'(in_acc && !reset && acc_we && !acc_err));
        chk("MemRead", s_mr, 64'(in_acc && !reset && !acc_we && !acc_err));
        if (in_acc) begin
            chk("Mem_Address", Mem_Address, acc_addr);
            if (acc_we) chk("Write_Data", Write_Data, acc_wdata);
            if (!reset) begin
                rsp_v    = 1'b1;
                rsp_cyc  = cyc + 1;
                rsp_own  = acc_own;
                rsp_err  = acc_err;
                rsp_data = (!acc_we && !acc_err) ? shadow[acc_addr >> 3] : 64'd0;
                if (acc_we && !acc_err) shadow[acc_addr >> 3] = acc_wdata;
            end
            acc_v = 1'b0;
        end

        req_c = cpu_bus.req;
        req_d = dma_bus.req;
        any   = !reset && !in_acc && (req_c || req_d);
        if (req_c && req_d) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            own = 1'b0;
`else
            own = !m_last;
`endif
        end else begin
            own = req_d;
        end
        eg_c = any && !own;
        eg_d = any && own;
        chk("cpu_gnt", s_gnt[0], 64'(eg_c));
        chk("dma_gnt", s_gnt[1], 64'(eg_d));
        if (any) begin
            a         = own ? dma_bus.addr : cpu_bus.addr;
            acc_v     = 1'b1;
            acc_cyc   = cyc + 1;
            acc_own   = own;
            acc_we    = own ? dma_bus.we : cpu_bus.we;
            acc_addr  = a;
            acc_wdata = own ? dma_bus.wdata : cpu_bus.wdata;
            acc_err   = (a % 8 != 0) || (a > 64'(MEM_BYTES - 8));
            m_last    = own;
        end
        if (reset) m_last = 1'b1;
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        s_gnt[0]   = cpu_bus.gnt;    s_gnt[1]   = dma_bus.gnt;
        s_rv[0]    = cpu_bus.rvalid; s_rv[1]    = dma_bus.rvalid;
        s_rdata[0] = cpu_bus.rdata;  s_rdata[1] = dma_bus.rdata;
        s_err[0]   = cpu_bus.err;    s_err[1]   = dma_bus.err;
        s_busy = busy; s_mw = MemWrite; s_mr = MemRead;
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input bit p, input bit rq, input bit we, input logic [63:0] addr, input logic [63:0] wd);
        if (p) begin
            dma_bus.req = rq; dma_bus.we = we; dma_bus.addr = addr; dma_bus.wdata = wd;
        end else begin
            cpu_bus.req = rq; cpu_bus.we = we; cpu_bus.addr = addr; cpu_bus.wdata = wd;
        end
    endtask

    task automatic do_req(input bit p, input bit we, input logic [63:0] addr, input logic [63:0] wd,
                          output logic [63:0] rdata, output bit err, output int lat, output bit mw, output bit mr);
        bit got = 1'b0;
        rdata = '0; err = 1'b0; lat = 0; mw = 1'b0; mr = 1'b0;
        set_port(p, 1'b1, we, addr, wd);
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = s_gnt[p];
        end
        set_port(p, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("gnt_timeout", 64'(got), 64'd1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            lat++;
            if (lat == 1) begin mw = s_mw; mr = s_mr; end
            if (s_rv[p]) begin got = 1'b1; rdata = s_rdata[p]; err = s_err[p]; end
        end
        chk("rvalid_timeout", 64'(got), 64'd1);
        $display("txn port=%s we=%0d addr=%0h wdata=%0h -> rdata=%0h err=%0d lat=%0d",
                 p ? "dma" : "cpu", we, addr, wd, rdata, err, lat);
    endtask

    function automatic logic [63:0] rand_addr();
        int k = $urandom_range(0, 9);
        if (k < 8)       return 64'($urandom_range(0, 7)) * 64'd8;
        else if (k == 8) return 64'($urandom_range(0, 7)) * 64'd8 + 64'($urandom_range(1, 7));
        else             return 64'(MEM_BYTES) + 64'($urandom_range(0, 31)) * 64'd8;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, word;
        bit          er, mw, mr, seen;
        int          lat;
        logic [7:0]  gc, gd;
        logic [63:0] cr, dr;
        bit          cv, dv;
        bit          pend [2];
        bit          pwe [2];
        logic [63:0] paddr [2], pwd [2];

        for (int i = 0; i < MEM_BYTES / 8; i++) shadow[i] = 64'd0;
        shadow[0] = 64'd2;
        shadow[1] = 64'd1;
        set_port(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_port(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        reset = 1'b1; preload = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        step();
        chk("reset_Mem_Address", Mem_Address, 64'd0);
        chk("reset_Write_Data", Write_Data, 64'd0);
        reset = 1'b0;

        // DMA store then load at 16
        do_req(1'b1, 1'b1, 64'd16, 64'h3, rd, er, lat, mw, mr);
        chk("st16_err", 64'(er), 64'd0);
        chk("st16_memwrite", 64'(mw), 64'd1);
        do_req(1'b1, 1'b0, 64'd16, 64'd0, rd, er, lat, mw, mr);
        chk("ld16_rdata", rd, 64'h3);
        chk("ld16_err", 64'(er), 64'd0);
        chk("ld16_latency", 64'(lat), 64'd2);

        // Both requesting from the first cycle after reset
        reset = 1'b1; step(); reset = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
        set_port(1'b1, 1'b1, 1'b0, 64'd8, 64'd0);
        gc = '0; gd = '0; cr = '0; dr = '0; cv = 1'b0; dv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            gc[i] = s_gnt[0];
            gd[i] = s_gnt[1];
            if (i == 2) begin cv = s_rv[0]; cr = s_rdata[0]; end
            if (i == 4) begin dv = s_rv[1]; dr = s_rdata[1]; end
        end
        set_port(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_port(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) step();
        chk("both_cpu_rv_c2", 64'(cv), 64'd1);
        chk("both_cpu_rdata_c2", cr, 64'd2);
`ifdef DMEM_ARB_CPU_PRIO_EN
        chk("prio_cpu_gnts", 64'(gc), 64'h55);
        chk("prio_dma_gnts", 64'(gd), 64'h00);
`else
        chk("rr_cpu_gnts", 64'(gc), 64'h11);
        chk("rr_dma_gnts", 64'(gd), 64'h44);
        chk("rr_dma_rv_c4", 64'(dv), 64'd1);
        chk("rr_dma_rdata_c4", dr, 64'd1);
`endif

        // Rejected accesses
        do_req(1'b0, 1'b0, 64'd12, 64'd0, rd, er, lat, mw, mr);
        chk("mis12_err", 64'(er), 64'd1);
        chk("mis12_rdata", rd, 64'd0);
        chk("mis12_memread", 64'(mr), 64'd0);
        do_req(1'b0, 1'b0, 64'd64, 64'd0, rd, er, lat, mw, mr);
        chk("oor64_err", 64'(er), 64'd1);
        chk("oor64_memread", 64'(mr), 64'd0);

        // Highest legal address
        do_req(1'b1, 1'b1, 64'd56, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat, mw, mr);
        chk("st56_err", 64'(er), 64'd0);
        for (int i = 0; i < 8; i++) word[8*i +: 8] = mem[56 + i];
        chk("st56_bytes", word, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req(1'b1, 1'b0, 64'd56, 64'd0, rd, er, lat, mw, mr);
        chk("ld56_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset during the ACCESS cycle of a CPU store
        set_port(1'b0, 1'b1, 1'b1, 64'd0, 64'd9);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin step(); seen = s_gnt[0]; end
        chk("rst_store_gnt", 64'(seen), 64'd1);
        set_port(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        reset = 1'b1; step(); reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin step(); seen |= s_rv[0]; end
        chk("rst_store_no_rvalid", 64'(seen), 64'd0);
        chk("rst_store_byte0", 64'(mem[0]), 64'd2);
        chk("rst_store_idle", 64'(s_busy), 64'd0);

        // Reset with a request present
        set_port(1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
        reset = 1'b1; step();
        chk("rst_req_no_gnt", 64'(s_gnt[0]), 64'd0);
        reset = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        step();

        // Random traffic
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && s_gnt[p]) pend[p] = 1'b0;
                if (!pend[p] && ($urandom_range(0, 99) < 50)) begin
                    pend[p]  = 1'b1;
                    pwe[p]   = 1'($urandom_range(0, 1));
                    paddr[p] = rand_addr();
                    pwd[p]   = {$urandom, $urandom};
                end
                set_port(1'(p), pend[p], pwe[p], paddr[p], pwd[p]);
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_port(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (4) step();

        for (int i = 0; i < MEM_BYTES / 8; i++) begin
            for (int b = 0; b < 8; b++) word[8*b +: 8] = mem[8*i + b];
            chk("final_mem", word, shadow[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
